// File: rtl/pc_gen_reg.sv
// pc_gen_reg: program-counter register for the RV32 fetch stage.
// Holds the fetch address, auto-increments on accepted fetches, handles
// stall/backpressure, branch/jump redirect (flush) and trap entry, and
// captures EPC / faulting address on a misaligned redirect target.
// Optional: define PC_COMPRESSED_EN for 16-bit (compressed) target alignment.
module pc_gen_reg #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned      INC          = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic [XLEN-1:0] epc_o,
  output logic [XLEN-1:0] badaddr_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   pc_next;
  logic [XLEN-1:0]   epc_next;
  logic [XLEN-1:0]   badaddr_next;
  logic              misalign_next;
  logic              target_misaligned;

`ifdef PC_COMPRESSED_EN
  assign target_misaligned = redirect_target_i[0];
`else
  assign target_misaligned = |redirect_target_i[1:0];
`endif

  assign pc_plus_o  = pc_o + INC_W;
  assign pc_valid_o = (state != BOOT);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-datapath selection; trap > misaligned redirect >
  // redirect (flush, overrides stall) > stall/backpressure > accept
  always_comb begin
    state_next    = state;
    pc_next       = pc_o;
    epc_next      = epc_o;
    badaddr_next  = badaddr_o;
    misalign_next = 1'b0;
    case (state)
      BOOT: begin
        state_next = RUN;
      end
      RUN, HOLD: begin
        if (trap_i) begin
          pc_next    = TRAP_VECTOR;
          epc_next   = pc_o;
          state_next = RUN;
        end else if (redirect_valid_i && target_misaligned) begin
          pc_next       = TRAP_VECTOR;
          epc_next      = pc_o;
          badaddr_next  = redirect_target_i;
          misalign_next = 1'b1;
          state_next    = RUN;
        end else if (redirect_valid_i) begin
          pc_next    = redirect_target_i;
          state_next = RUN;
        end else if (stall_i || !fetch_ready_i) begin
          state_next = HOLD;
        end else begin
          pc_next    = pc_plus_o;
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Datapath registers: PC, exception PC, bad address and misalign pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o       <= RESET_VECTOR;
      epc_o      <= '0;
      badaddr_o  <= '0;
      misalign_o <= 1'b0;
    end else begin
      pc_o       <= pc_next;
      epc_o      <= epc_next;
      badaddr_o  <= badaddr_next;
      misalign_o <= misalign_next;
    end
  end

endmodule

// File: tb/tb_pc_gen_reg.sv
// Testbench for pc_gen_reg: directed scenarios plus randomized traffic,
// checked against a behavioural model of the PC rules.
module tb_pc_gen_reg;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redir;
  logic [31:0] target;
  logic        trap;
  logic        ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] pc_plus;
  logic [31:0] epc;
  logic [31:0] badaddr;
  logic        misalign;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [31:0] m_bad;
  logic        m_mis;
  logic        m_booted;

  pc_gen_reg #(
    .XLEN        (32),
    .RESET_VECTOR(RESET_VEC),
    .TRAP_VECTOR (TRAP_VEC),
    .INC         (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .redirect_valid_i (redir),
    .redirect_target_i(target),
    .trap_i           (trap),
    .fetch_ready_i    (ready),
    .pc_o             (pc),
    .pc_valid_o       (pc_valid),
    .pc_plus_o        (pc_plus),
    .epc_o            (epc),
    .badaddr_o        (badaddr),
    .misalign_o       (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit is_misaligned(input logic [31:0] t);
`ifdef PC_COMPRESSED_EN
    return (t % 2) != 0;
`else
    return (t % 4) != 0;
`endif
  endfunction

  task automatic model_reset();
    m_pc     = RESET_VEC;
    m_epc    = 0;
    m_bad    = 0;
    m_mis    = 0;
    m_booted = 0;
  endtask

  // one clock edge of the architectural rules
  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else if (!m_booted) begin
      m_booted = 1;
      m_mis    = 0;
    end else begin
      m_mis = 0;
      if (trap) begin
        m_epc = m_pc;
        m_pc  = TRAP_VEC;
      end else if (redir && is_misaligned(target)) begin
        m_epc = m_pc;
        m_bad = target;
        m_mis = 1;
        m_pc  = TRAP_VEC;
      end else if (redir) begin
        m_pc = target;
      end else if (!stall && ready) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},       pc,               m_pc);
    check({tag, ".valid"},    {31'd0, pc_valid}, {31'd0, m_booted});
    check({tag, ".pc_plus"},  pc_plus,          m_pc + 32'd4);
    check({tag, ".epc"},      epc,              m_epc);
    check({tag, ".badaddr"},  badaddr,          m_bad);
    check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_mis});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    stall = 0; redir = 0; target = 0; trap = 0; ready = 1;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, pc_valid}, 32'd0);
    for (int i = 0; i < 3; i++) step("in_reset");
    rst = 1;

    // boot then accepts
    step("boot");
    check("boot_pc", pc, 32'h0);
    check("boot_valid", {31'd0, pc_valid}, 32'd1);
    step("acc4");  check("pc4", pc, 32'h4);
    step("acc8");  check("pc8", pc, 32'h8);

    // stall and backpressure
    stall = 1;
    step("stall1"); step("stall2"); check("stall_hold", pc, 32'h8);
    stall = 0; ready = 0;
    step("nready"); check("nready_hold", pc, 32'h8);
    ready = 1;
    step("release"); check("release_pc", pc, 32'hC);

    // redirect over stall
    stall = 1; redir = 1; target = 32'h40;
    step("redir_stall"); check("redir_stall_pc", pc, 32'h40);
    stall = 0; redir = 0;
    step("after_redir"); check("after_redir_pc", pc, 32'h44);

    // misaligned redirect
    redir = 1; target = 32'h10;
    step("to10");
    target = 32'h22;
    step("mis");
`ifdef PC_COMPRESSED_EN
    check("mis_pc", pc, 32'h22);
    check("mis_flag", {31'd0, misalign}, 32'd0);
`else
    check("mis_pc", pc, 32'h100);
    check("mis_epc", epc, 32'h10);
    check("mis_bad", badaddr, 32'h22);
    check("mis_flag", {31'd0, misalign}, 32'd1);
`endif
    redir = 0; stall = 1;
    step("mis_after"); check("mis_pulse_end", {31'd0, misalign}, 32'd0);
    stall = 0;

    // trap vs redirect collision
    redir = 1; target = 32'h30;
    step("to30");
    trap = 1; target = 32'h80;
    step("trap_col");
    check("trap_pc", pc, 32'h100);
    check("trap_epc", epc, 32'h30);
    trap = 0; redir = 0;

    // wrap-around
    redir = 1; target = 32'hFFFF_FFFC;
    step("toFFFC"); check("wrap_plus", pc_plus, 32'h0);
    redir = 0;
    step("wrap"); check("wrap_pc", pc, 32'h0);
    step("post_wrap");

    // asynchronous reset mid-cycle
    #2 rst = 0;
    #1;
    model_reset();
    check("async_pc", pc, 32'h0);
    check("async_valid", {31'd0, pc_valid}, 32'd0);
    check_all("async");
    step("async_hold");

    // trap/redirect ignored during boot
    rst = 1; trap = 1; redir = 1; target = 32'h81;
    step("boot_ignore");
    check("boot_ignore_pc", pc, 32'h0);
    idle_inputs();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall  = ($urandom_range(0, 3) == 0);
      ready  = ($urandom_range(0, 4) != 0);
      redir  = ($urandom_range(0, 4) == 0);
      trap   = ($urandom_range(0, 19) == 0);
      target = $urandom;
      if ($urandom_range(0, 1) == 0) target[1:0] = 2'b00;
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 0;
        #1;
        model_reset();
        check_all("rnd_async");
        @(negedge clk);
        rst = 1;
      end
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen_reg.md
Name: pc_gen_reg

Overview:
Parametrised program-counter register for the RISC-V32 fetch stage. It is the successor to the plain PC register.
- Holds the current fetch address and presents it to instruction memory with a valid/ready handshake.
- Auto-increments on each accepted fetch.
- Supports stall, branch/jump redirect and trap entry.
- Captures the exception PC and the faulting address when a redirect target is misaligned.

Parameters:
XLEN, 32, datapath/address width in bits
RESET_VECTOR, 32'h0000_0000, pc_o value on reset
TRAP_VECTOR, 32'h0000_0100, pc_o value loaded on trap or misaligned redirect
INC, 4, increment added to pc_o per accepted fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
stall_i  in  1  hazard stall; holds pc_o
redirect_valid_i  in  1  branch/jump taken this cycle
redirect_target_i  in  XLEN  branch/jump target
trap_i  in  1  external trap request (ecall, illegal instruction, ...)
fetch_ready_i  in  1  instruction memory accepts pc_o
pc_o  out  XLEN  current fetch address
pc_valid_o  out  1  pc_o is a valid fetch request
pc_plus_o  out  XLEN  pc_o + INC, combinational, wraps modulo 2^XLEN
epc_o  out  XLEN  PC captured on trap entry
badaddr_o  out  XLEN  faulting target of a misaligned redirect
misalign_o  out  1  one-cycle pulse flagging a misaligned redirect

Behaviour:
- Reset (rst=0, asynchronous, immediate, also mid-operation):
  - pc_o=RESET_VECTOR, pc_valid_o=0, epc_o=0, badaddr_o=0, misalign_o=0, state=BOOT.
- States: BOOT, RUN, HOLD.
  - BOOT: entered on reset. First clk edge after rst=1 goes to RUN and sets pc_valid_o=1; pc_o stays RESET_VECTOR.
  - RUN: pc_valid_o=1.
  - HOLD: pc_valid_o=1, pc_o frozen. Entered when stall_i=1 or fetch_ready_i=0. Exits to RUN on the first edge where stall_i=0 and fetch_ready_i=1, or on any redirect/trap.
- Per-edge priority, outside BOOT, highest first:
  1. trap_i=1:
     - pc_o<=TRAP_VECTOR, epc_o<=pc_o, state<=RUN.
     - Any redirect in the same cycle is ignored.
  2. redirect_valid_i=1 with misaligned target:
     - pc_o<=TRAP_VECTOR, epc_o<=pc_o, badaddr_o<=redirect_target_i, misalign_o<=1 for exactly one cycle.
  3. redirect_valid_i=1 with aligned target:
     - pc_o<=redirect_target_i, state<=RUN.
     - Applies even if stall_i=1 or fetch_ready_i=0; this is a flush.
  4. stall_i=1 or fetch_ready_i=0: pc_o held, state<=HOLD.
  5. Otherwise (accept): pc_o<=pc_o+INC.
- In BOOT, trap_i and redirect_valid_i are ignored.
- Alignment: misaligned means redirect_target_i[1:0]!=0.
- Wrap-around: pc_o=32'hFFFF_FFFC with an accept gives pc_o=32'h0000_0000. No flag is raised.
- misalign_o is a registered output that is 0 on every cycle except the one following a misaligned redirect.
- epc_o and badaddr_o hold their values until the next trap or misaligned redirect.

Optional Feature:
Macro PC_COMPRESSED_EN.
- Defined: 16-bit compressed instruction alignment.
  - Misaligned means redirect_target_i[0]!=0 only; targets like 32'h0000_0102 are accepted.
  - INC is unchanged; the decoder supplies +2 via redirect.
- Undefined: 32-bit alignment rule as in Behaviour (bits [1:0]).

Test Plan:
- Reset and boot: hold rst=0 for 3 cycles, then release with fetch_ready_i=1.
  - During reset: pc_o=0, pc_valid_o=0.
  - First edge: pc_valid_o=1, pc_o=0.
  - Next edges: pc_o=4, 8, 12.
- Stall and backpressure: stall_i=1 for 2 cycles at pc_o=8 → pc_o stays 8. Then fetch_ready_i=0 for 1 cycle → still 8. Release both → 12.
- Redirect over stall: stall_i=1, redirect_valid_i=1, target=32'h40 → next pc_o=32'h40. After release → 32'h44.
- Misaligned redirect: pc_o=32'h10, target=32'h22 → pc_o=32'h100, epc_o=32'h10, badaddr_o=32'h22, misalign_o=1 for one cycle.
  - With PC_COMPRESSED_EN defined, the same stimulus gives pc_o=32'h22, misalign_o=0.
- Trap vs redirect collision: trap_i=1 and redirect to 32'h80 in the same cycle at pc_o=32'h30 → pc_o=32'h100, epc_o=32'h30.
- Wrap and async reset: redirect to 32'hFFFF_FFFC, accept → pc_o=0.
  - Assert rst=0 mid-cycle → pc_o=0 and pc_valid_o=0 immediately, before any clk edge.
